// File: rtl/memory_fifo_ctrl.sv
// FIFO controller that uses a plain single-word-per-address memory as backing store.
// Words stream in, are written at sequential addresses, then read back in order.
module memory_fifo_ctrl #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int MEMORY_QTY   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_SIZE-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_SIZE-1:0]    out_data,
  output logic [ADDRESS_SIZE:0]   level,
  output logic                    empty,
  output logic                    full,
  output logic                    mem_w_en,
  output logic [ADDRESS_SIZE-1:0] mem_w_addr,
  output logic [WORD_SIZE-1:0]    mem_w_data,
  input  logic                    mem_w_ready,
  output logic                    mem_r_en,
  output logic [ADDRESS_SIZE-1:0] mem_r_addr,
  input  logic [WORD_SIZE-1:0]    mem_r_data,
  input  logic                    mem_r_ready
);

  localparam int LW = ADDRESS_SIZE + 1;
  localparam logic [LW-1:0] QTY = LW'(MEMORY_QTY);
  localparam logic [ADDRESS_SIZE-1:0] LAST = ADDRESS_SIZE'(MEMORY_QTY - 1);

  typedef enum logic {
    W_IDLE,
    W_BUSY
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_BUSY,
    R_HOLD
  } r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [ADDRESS_SIZE-1:0] wr_ptr;
  logic [ADDRESS_SIZE-1:0] rd_ptr;
  logic [LW-1:0]           avail;

  logic push;
  logic pop;
  logic commit;
  logic fetch;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [ADDRESS_SIZE-1:0] next_ptr(
    input logic [ADDRESS_SIZE-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_ready = !reset && (w_state == W_IDLE) && (level < QTY);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign commit   = (w_state == W_BUSY) && mem_w_ready;
  assign fetch    = (r_state == R_BUSY) && mem_r_ready;
  assign empty    = (level == '0);
  assign full     = (level == QTY);

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state    <= W_IDLE;
      mem_w_en   <= 1'b0;
      mem_w_addr <= '0;
      mem_w_data <= '0;
      wr_ptr     <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (push) begin
            mem_w_data <= in_data;
            mem_w_addr <= wr_ptr;
            mem_w_en   <= 1'b1;
            w_state    <= W_BUSY;
          end
        end
        W_BUSY: begin
          if (mem_w_ready) begin
            mem_w_en <= 1'b0;
            wr_ptr   <= next_ptr(wr_ptr);
            w_state  <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= R_IDLE;
      mem_r_en   <= 1'b0;
      mem_r_addr <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      rd_ptr     <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (avail != '0) begin
            mem_r_en   <= 1'b1;
            mem_r_addr <= rd_ptr;
            r_state    <= R_BUSY;
          end
        end
        R_BUSY: begin
          if (mem_r_ready) begin
            out_data  <= mem_r_data;
            out_valid <= 1'b1;
            mem_r_en  <= 1'b0;
            rd_ptr    <= next_ptr(rd_ptr);
            r_state   <= R_HOLD;
          end
        end
        R_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // level gates writes against unconsumed words; avail gates reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      level <= '0;
      avail <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      unique case ({commit, fetch})
        2'b10:   avail <= avail + 1'b1;
        2'b01:   avail <= avail - 1'b1;
        default: avail <= avail;
      endcase
    end
  end

endmodule
